bsg_mcl_host_fifo_bridge: RTL and testbench

Host-side bridge between a 32-bit host word interface and the 128-bit request/response packet FIFOs of the manycore endpoint adapter. It assembles four host-written words into one outbound packet, and buffers inbound packets, returning each to the host as four words. It also reports the receive-buffer vacancy that the adapter uses to throttle host load requests. One instance serves one FIFO direction pair, meaning one request-out stream and one packet-in stream.

---
 rtl/bsg_mcl_host_fifo_bridge.sv | 137 +++++++++++++
 tb/tb_bsg_mcl_host_fifo_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mcl_host_fifo_bridge.sv
// rtl/bsg_mcl_host_fifo_bridge.sv - 32-bit host word <-> 128-bit packet FIFO bridge
// Optional outbound stall counter enabled by BSG_MCL_HOST_BRIDGE_STALL_CNT_EN.
module bsg_mcl_host_fifo_bridge #(
  parameter int fifo_width_p   = 128,
  parameter int word_width_p   = 32,
  parameter int rcv_fifo_els_p = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   host_wr_v_i,
  input  logic [word_width_p-1:0]                host_wr_data_i,
  output logic                                   host_wr_ready_o,
  output logic                                   fifo_v_o,
  output logic [fifo_width_p-1:0]                fifo_data_o,
  input  logic                                   fifo_ready_i,
  input  logic                                   fifo_v_i,
  input  logic [fifo_width_p-1:0]                fifo_data_i,
  output logic                                   fifo_ready_o,
  output logic                                   host_rd_v_o,
  output logic [word_width_p-1:0]                host_rd_data_o,
  input  logic                                   host_rd_yumi_i,
  output logic [$clog2(rcv_fifo_els_p+1)-1:0]    rcv_vacancy_o,
  output logic [31:0]                            stall_count_o
);

  localparam int cnt_w = $clog2(rcv_fifo_els_p + 1);
  localparam int ptr_w = $clog2(rcv_fifo_els_p);
  localparam logic [cnt_w-1:0] els_c = cnt_w'(rcv_fifo_els_p);

  // TX assembler
  typedef enum logic {FILL, SEND} tx_state_e;

  tx_state_e                 tx_state_r;
  logic [1:0]                wr_cnt_r;
  logic [fifo_width_p-1:0]   pkt_r;
  logic                      wr_acc;

  assign wr_acc      = host_wr_v_i & host_wr_ready_o;
  assign fifo_data_o = pkt_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_state_r      <= FILL;
      wr_cnt_r        <= 2'd0;
      pkt_r           <= '0;
      host_wr_ready_o <= 1'b1;
      fifo_v_o        <= 1'b0;
    end else begin
      case (tx_state_r)
        FILL: begin
          if (wr_acc) begin
            pkt_r[int'(wr_cnt_r)*word_width_p +: word_width_p] <= host_wr_data_i;
            wr_cnt_r <= wr_cnt_r + 2'd1;
            if (wr_cnt_r == 2'd3) begin
              tx_state_r      <= SEND;
              host_wr_ready_o <= 1'b0;
              fifo_v_o        <= 1'b1;
            end
          end
        end
        SEND: begin
          if (fifo_ready_i) begin
            tx_state_r      <= FILL;
            wr_cnt_r        <= 2'd0;
            host_wr_ready_o <= 1'b1;
            fifo_v_o        <= 1'b0;
          end
        end
        default: begin
          tx_state_r      <= FILL;
          wr_cnt_r        <= 2'd0;
          host_wr_ready_o <= 1'b1;
          fifo_v_o        <= 1'b0;
        end
      endcase
    end
  end

  // RX buffer and word serializer
  logic [fifo_width_p-1:0] mem_r [rcv_fifo_els_p];
  logic [ptr_w-1:0]        wr_ptr_r;
  logic [ptr_w-1:0]        rd_ptr_r;
  logic [cnt_w-1:0]        count_r;
  logic [1:0]              rd_cnt_r;
  logic                    push;
  logic                    yumi;
  logic                    pop;

  assign fifo_ready_o   = (count_r != els_c);
  assign host_rd_v_o    = (count_r != '0);
  assign push           = fifo_v_i & fifo_ready_o;
  assign yumi           = host_rd_yumi_i & host_rd_v_o;
  assign pop            = yumi & (rd_cnt_r == 2'd3);
  assign host_rd_data_o = mem_r[rd_ptr_r][int'(rd_cnt_r)*word_width_p +: word_width_p];
  assign rcv_vacancy_o  = els_c - count_r;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_r[wr_ptr_r] <= fifo_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      rd_cnt_r <= 2'd0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      if (yumi) rd_cnt_r <= rd_cnt_r + 2'd1;
      if (pop)  rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef BSG_MCL_HOST_BRIDGE_STALL_CNT_EN
  logic [31:0] stall_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_r <= '0;
    end else if (fifo_v_o && !fifo_ready_i && (stall_r != '1)) begin
      stall_r <= stall_r + 32'd1;
    end
  end

  assign stall_count_o = stall_r;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mcl_host_fifo_bridge.sv
// tb/tb_bsg_mcl_host_fifo_bridge.sv - scoreboard bench for bsg_mcl_host_fifo_bridge
module tb_bsg_mcl_host_fifo_bridge;

  localparam int els = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         host_wr_v;
  logic [31:0]  host_wr_data;
  logic         host_wr_ready_o;
  logic         fifo_v_o;
  logic [127:0] fifo_data_o;
  logic         fifo_ready_i;
  logic         fifo_v_i;
  logic [127:0] fifo_data_i;
  logic         fifo_ready_o;
  logic         host_rd_v_o;
  logic [31:0]  host_rd_data_o;
  logic         host_rd_yumi;
  logic [4:0]   rcv_vacancy_o;
  logic [31:0]  stall_count_o;

  logic [127:0] tx_exp [$];
  logic [31:0]  rx_exp [$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] p;
  logic [31:0]  w;
  logic         pushed;

  always #5 clk = ~clk;

  bsg_mcl_host_fifo_bridge #(
    .fifo_width_p  (128),
    .word_width_p  (32),
    .rcv_fifo_els_p(els)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (resetn),
    .host_wr_v_i    (host_wr_v),
    .host_wr_data_i (host_wr_data),
    .host_wr_ready_o(host_wr_ready_o),
    .fifo_v_o       (fifo_v_o),
    .fifo_data_o    (fifo_data_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_v_i       (fifo_v_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_ready_o   (fifo_ready_o),
    .host_rd_v_o    (host_rd_v_o),
    .host_rd_data_o (host_rd_data_o),
    .host_rd_yumi_i (host_rd_yumi),
    .rcv_vacancy_o  (rcv_vacancy_o),
    .stall_count_o  (stall_count_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every handshake against the queued expectation
  always @(negedge clk) begin
    if (resetn) begin
      if (fifo_v_o && fifo_ready_i) begin
        if (tx_exp.size() == 0) check("tx_extra_pkt", fifo_v_o, 1'b0);
        else check("tx_pkt", fifo_data_o, tx_exp.pop_front());
      end
      if (host_rd_v_o && host_rd_yumi) begin
        if (rx_exp.size() == 0) check("rx_extra_word", host_rd_v_o, 1'b0);
        else check("rx_word", host_rd_data_o, rx_exp.pop_front());
      end
    end
  end

  function automatic logic [127:0] mk(input int i);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'hA000_0000 | 32'(i << 8) | 32'(j);
    return r;
  endfunction

  task automatic wr_word(input logic [31:0] d);
    host_wr_v    = 1'b1;
    host_wr_data = d;
    for (int i = 0; i < 100 && !host_wr_ready_o; i++) begin
      @(posedge clk); #1;
    end
    check("wr_ready_wait", host_wr_ready_o, 1'b1);
    @(posedge clk); #1;
    host_wr_v = 1'b0;
  endtask

  task automatic wr_pkt(input logic [127:0] pk);
    tx_exp.push_back(pk);
    for (int j = 0; j < 4; j++) wr_word(pk[32*j +: 32]);
    check("tx_latency_v", fifo_v_o, 1'b1);
    check("tx_send_ready", host_wr_ready_o, 1'b0);
  endtask

  task automatic push_pkt(input int i);
    logic [127:0] pk;
    pk = mk(i);
    for (int j = 0; j < 4; j++) rx_exp.push_back(pk[32*j +: 32]);
    fifo_v_i    = 1'b1;
    fifo_data_i = pk;
    for (int k = 0; k < 100 && !fifo_ready_o; k++) begin
      @(posedge clk); #1;
    end
    check("rx_ready_wait", fifo_ready_o, 1'b1);
    @(posedge clk); #1;
    fifo_v_i = 1'b0;
  endtask

  task automatic read_word();
    for (int k = 0; k < 100 && !host_rd_v_o; k++) begin
      @(posedge clk); #1;
    end
    check("rd_valid_wait", host_rd_v_o, 1'b1);
    host_rd_yumi = 1'b1;
    @(posedge clk); #1;
    host_rd_yumi = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wr_ready"}, host_wr_ready_o, 1'b1);
    check({tag, "_fifo_v"}, fifo_v_o, 1'b0);
    check({tag, "_fifo_data"}, fifo_data_o, 128'h0);
    check({tag, "_fifo_ready"}, fifo_ready_o, 1'b1);
    check({tag, "_rd_v"}, host_rd_v_o, 1'b0);
    check({tag, "_vacancy"}, rcv_vacancy_o, 5'd16);
    check({tag, "_stall"}, stall_count_o, 32'd0);
  endtask

  initial begin
    resetn       = 1'b0;
    host_wr_v    = 1'b0;
    host_wr_data = '0;
    fifo_ready_i = 1'b0;
    fifo_v_i     = 1'b0;
    fifo_data_i  = '0;
    host_rd_yumi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    resetn = 1'b1;
    @(posedge clk); #1;

    // TX assembly with the adapter stalling for 10 cycles
    tx_exp.push_back(128'h44444444_33333333_22222222_11111111);
    wr_word(32'h11111111);
    wr_word(32'h22222222);
    wr_word(32'h33333333);
    wr_word(32'h44444444);
    check("tx_v_after_4th", fifo_v_o, 1'b1);
    check("tx_data", fifo_data_o, 128'h44444444_33333333_22222222_11111111);
    check("tx_5th_held", host_wr_ready_o, 1'b0);
    host_wr_v    = 1'b1;
    host_wr_data = 32'h55555555;
    repeat (10) @(posedge clk);
    #1;
`ifdef BSG_MCL_HOST_BRIDGE_STALL_CNT_EN
    check("stall_count", stall_count_o, 32'd10);
`else
    check("stall_count_off", stall_count_o, 32'd0);
`endif
    check("tx_5th_still_held", host_wr_ready_o, 1'b0);
    check("tx_data_stable", fifo_data_o, 128'h44444444_33333333_22222222_11111111);
    fifo_ready_i = 1'b1;
    @(posedge clk); #1;
    check("tx_v_after_hs", fifo_v_o, 1'b0);
    check("tx_ready_after_hs", host_wr_ready_o, 1'b1);
    tx_exp.push_back(128'h88888888_77777777_66666666_55555555);
    wr_word(32'h55555555);
    wr_word(32'h66666666);
    wr_word(32'h77777777);
    wr_word(32'h88888888);
    check("tx2_v", fifo_v_o, 1'b1);
    @(posedge clk); #1;
    check("tx2_done", fifo_v_o, 1'b0);
    check("tx_drained", tx_exp.size(), 0);

    // RX fill to full, partial drain, simultaneous push/pop at full
    for (int i = 0; i < els; i++) push_pkt(i);
    check("rx_full_ready", fifo_ready_o, 1'b0);
    check("rx_full_vacancy", rcv_vacancy_o, 5'd0);
    for (int j = 0; j < 4; j++) read_word();
    check("rx_vacancy_1", rcv_vacancy_o, 5'd1);
    push_pkt(els);
    check("rx_refull_vacancy", rcv_vacancy_o, 5'd0);
    for (int j = 0; j < 3; j++) read_word();
    p = mk(els + 1);
    for (int j = 0; j < 4; j++) rx_exp.push_back(p[32*j +: 32]);
    fifo_v_i     = 1'b1;
    fifo_data_i  = p;
    host_rd_yumi = 1'b1;
    pushed       = fifo_ready_o;
    @(posedge clk); #1;
    host_rd_yumi = 1'b0;
    if (!pushed) begin
      for (int k = 0; k < 100 && !fifo_ready_o; k++) begin
        @(posedge clk); #1;
      end
      check("rx_sim_ready_wait", fifo_ready_o, 1'b1);
      @(posedge clk); #1;
    end
    fifo_v_i = 1'b0;
    check("rx_sim_full_vacancy", rcv_vacancy_o, 5'd0);
    for (int i = els + 2; i < 3 * els; i++) begin
      if (!fifo_ready_o) for (int j = 0; j < 4; j++) read_word();
      push_pkt(i);
    end
    for (int k = 0; k < 400 && host_rd_v_o; k++) read_word();
    check("rx_drained_q", rx_exp.size(), 0);
    check("rx_empty_v", host_rd_v_o, 1'b0);
    check("rx_empty_vacancy", rcv_vacancy_o, 5'd16);

    // Reset in the middle of a TX packet and an RX packet
    wr_word(32'hDEAD0001);
    wr_word(32'hDEAD0002);
    push_pkt(3 * els);
    p = mk(3 * els);
    w = p[31:0];
    check("rx_latency_v", host_rd_v_o, 1'b1);
    check("rx_latency_w0", host_rd_data_o, w);
    read_word();
    resetn = 1'b0;
    rx_exp.delete();
    @(posedge clk); #1;
    reset_checks("midrst");
    resetn = 1'b1;
    wr_pkt(128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_C0C0C0C0);
    check("post_rst_data", fifo_data_o, 128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_C0C0C0C0);
    @(posedge clk); #1;
    check("post_rst_tx_drained", tx_exp.size(), 0);
    check("post_rst_rd_v", host_rd_v_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
